ft2232h_tx_controller: RTL and testbench



---
 rtl/ft2232h_pkg.sv | 22 ++
 rtl/ft2232h_tx_controller_if.sv | 36 +++
 rtl/ft2232h_tx_fifo.sv | 76 +++++++
 rtl/ft2232h_tx_controller.sv | 146 ++++++++++++++
 tb/tb_ft2232h_tx_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H FT245-synchronous transmit path:
// controller state encoding, pin polarity constants and default sizing.
// Optional feature macro used by the controller: FT2232H_TX_SIWU_EN.
package ft2232h_pkg;

    // Controller states: idle, bus turnaround/setup, active write strobe.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Pin levels; TXE#, WR# and SI/WU# are all active-low.
    localparam logic HI = 1'b1;
    localparam logic LO = 1'b0;

    // Default sizing.
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_FIFO_AW    = 4;
    localparam int DEF_SIWU_IDLE  = 32;

endpackage

// File: rtl/ft2232h_tx_controller_if.sv
// Signal bundle between the byte producer, the transmit controller and the
// FT2232H pins. Names carry the controller's direction suffix.
//
// Handshakes:
//   producer -> controller: a byte moves on a rising edge of clk where
//     wvalid_i & wready_o; wready_o depends only on FIFO occupancy, never on
//     wvalid_i, and wvalid_i may be raised or dropped in any cycle.
//   controller -> FT2232H: a byte moves on a rising edge where wr_o == 0 and
//     txe_i == 0; if txe_i is high while wr_o is low the same byte stays on
//     data_o and nothing is consumed.
interface ft2232h_tx_controller_if;
    import ft2232h_pkg::*;

    logic       txe_i;
    logic       wr_o;
    logic [7:0] data_o;
    logic       data_oe_o;
    logic [7:0] wdata_i;
    logic       wvalid_i;
    logic       wready_o;
    logic       siwu_o;
    state_e     state_o;   // controller state, for observation only

    // Controller side.
    modport master (
        input  txe_i, wdata_i, wvalid_i,
        output wr_o, data_o, data_oe_o, wready_o, siwu_o, state_o
    );

    // Environment side: pins plus producer.
    modport slave (
        output txe_i, wdata_i, wvalid_i,
        input  wr_o, data_o, data_oe_o, wready_o, siwu_o, state_o
    );

endinterface

// File: rtl/ft2232h_tx_fifo.sv
// Synchronous show-ahead byte FIFO: dout_o always shows the head entry.
// Push is ignored when full and pop is ignored when empty; a simultaneous
// push and pop leaves the count unchanged.
module ft2232h_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ft2232h_tx_controller.sv
// FT2232H FT245 synchronous FIFO-mode transmitter. Buffers producer bytes in
// a show-ahead FIFO and streams them to the chip with WR#, gated by TXE#.
// A DRIVE cycle always separates bus enable and WR# activity, giving one
// setup cycle before the first strobe and one hold cycle after the last.
// Optional macro FT2232H_TX_SIWU_EN adds a send-immediate pulse on SI/WU#
// after SIWU_IDLE idle cycles following a write.
module ft2232h_tx_controller
    import ft2232h_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FIFO_AW    = DEF_FIFO_AW,
    parameter int SIWU_IDLE  = DEF_SIWU_IDLE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ft2232h_tx_controller_if.master  bus
);

    state_e           state_q;
    logic             wr_q;
    logic             oe_q;
    logic             siwu_w;

    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [7:0]       fifo_head;
    logic             accept;
    logic [FIFO_AW:0] count_after;

    // Unsupported sizing leaves this marker block elaborated; nothing else.
    if (FIFO_DEPTH != (1 << FIFO_AW) || FIFO_DEPTH < 4 || SIWU_IDLE < 1) begin : g_bad_config
    end

    // A byte leaves the FIFO only when the chip actually takes it.
    assign accept      = (wr_q == LO) && (bus.txe_i == LO);
    assign count_after = fifo_count - {{FIFO_AW{1'b0}}, accept};

    ft2232h_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.wvalid_i),
        .din_i   (bus.wdata_i),
        .pop_i   (accept),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.wready_o  = !fifo_full;
    assign bus.data_o    = fifo_head;
    assign bus.wr_o      = wr_q;
    assign bus.data_oe_o = oe_q;
    assign bus.siwu_o    = siwu_w;
    assign bus.state_o   = state_q;

    // Write-strobe FSM with registered WR# and bus enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wr_q    <= HI;
            oe_q    <= LO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && bus.txe_i == LO) begin
                        state_q <= ST_DRIVE;
                        wr_q    <= HI;
                        oe_q    <= HI;
                    end else begin
                        wr_q    <= HI;
                        oe_q    <= LO;
                    end
                end
                ST_DRIVE: begin
                    if (!fifo_empty && bus.txe_i == LO) begin
                        state_q <= ST_WRITE;
                        wr_q    <= LO;
                        oe_q    <= HI;
                    end else begin
                        state_q <= ST_IDLE;
                        wr_q    <= HI;
                        oe_q    <= LO;
                    end
                end
                ST_WRITE: begin
                    if (bus.txe_i == LO && count_after != '0) begin
                        wr_q    <= LO;
                        oe_q    <= HI;
                    end else begin
                        state_q <= ST_DRIVE;
                        wr_q    <= HI;
                        oe_q    <= HI;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wr_q    <= HI;
                    oe_q    <= LO;
                end
            endcase
        end
    end

`ifdef FT2232H_TX_SIWU_EN
    localparam int SIWU_W = $clog2(SIWU_IDLE) + 1;
    localparam logic [SIWU_W-1:0] SIWU_LAST = SIWU_W'(SIWU_IDLE - 1);
    localparam logic [SIWU_W-1:0] SIWU_ONE  = SIWU_W'(1);

    logic [SIWU_W-1:0] idle_cnt_q;
    logic              armed_q;
    logic              siwu_q;

    assign siwu_w = siwu_q;

    // Idle timer: armed by a write, one SI/WU# pulse after SIWU_IDLE empty idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_q <= '0;
            armed_q    <= 1'b0;
            siwu_q     <= HI;
        end else begin
            siwu_q <= HI;
            if (accept) begin
                idle_cnt_q <= '0;
                armed_q    <= 1'b1;
            end else if (armed_q && state_q == ST_IDLE && fifo_empty) begin
                if (idle_cnt_q == SIWU_LAST) begin
                    siwu_q     <= LO;
                    armed_q    <= 1'b0;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + SIWU_ONE;
                end
            end
        end
    end
`else
    assign siwu_w = HI;
`endif

endmodule

// File: tb/tb_ft2232h_tx_controller.sv
// Testbench for ft2232h_tx_controller: directed timing checks plus a
// randomized phase, with a producer/receiver scoreboard tracking every byte.
module tb_ft2232h_tx_controller;

    localparam int DEPTH = 16;
`ifdef FT2232H_TX_SIWU_EN
    localparam int EXP_PULSES = 1;
`else
    localparam int EXP_PULSES = 0;
`endif

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         rx_cnt     = 0;
    int         siwu_pulse = 0;
    bit         mon_en     = 0;
    bit         stall_pend = 0;

    ft2232h_tx_controller_if bus ();

    ft2232h_tx_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.wdata_i  = b;
        bus.wvalid_i = 1'b1;
        step();
        bus.wvalid_i = 1'b0;
    endtask

    task automatic wait_wr_low(input int budget);
        int n;
        n = 0;
        while (bus.wr_o !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check("wr_low_wait", bus.wr_o, 1'b0);
    endtask

    // ---------------- scoreboard / receiver model ----------------
    // Sampled on the falling edge: the values seen here are what the next
    // rising edge acts on. Producer pushes enter exp_q, chip accepts leave it.
    always @(negedge clk) begin
        if (mon_en) begin
            check("wready_vs_occupancy", bus.wready_o, (exp_q.size() < DEPTH));
`ifdef FT2232H_TX_SIWU_EN
            if (bus.siwu_o === 1'b0) siwu_pulse++;
`else
            check("siwu_held_high", bus.siwu_o, 1'b1);
`endif
            if (stall_pend) begin
                check("stall_one_cycle", bus.wr_o, 1'b1);
                stall_pend = 0;
            end
            if (rst) begin
                exp_q.delete();
            end else begin
                if (bus.wr_o === 1'b0) begin
                    check("oe_during_write", bus.data_oe_o, 1'b1);
                    if (bus.txe_i === 1'b1) stall_pend = 1;
                end
                if (bus.wr_o === 1'b0 && bus.txe_i === 1'b0) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        check("rx_without_pending_byte", bus.wr_o, 1'b1);
                    end else begin
                        check("rx_data", bus.data_o, exp_q.pop_front());
                    end
                end
                if (bus.wvalid_i === 1'b1 && bus.wready_o === 1'b1) begin
                    exp_q.push_back(bus.wdata_i);
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int rx0;

        rst          = 1'b1;
        bus.txe_i    = 1'b1;
        bus.wvalid_i = 1'b0;
        bus.wdata_i  = 8'h00;

        // Reset held with TXE# high: outputs at reset values every cycle.
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_wr", bus.wr_o, 1'b1);
            check("rst_oe", bus.data_oe_o, 1'b0);
            check("rst_wready", bus.wready_o, 1'b1);
            check("rst_siwu", bus.siwu_o, 1'b1);
        end
        mon_en = 1;

        // Single byte 0xA5: DRIVE after edge N+1, WR# low after N+2, taken at N+3.
        rst       = 1'b0;
        bus.txe_i = 1'b0;
        step();
        check("idle_wr", bus.wr_o, 1'b1);
        push_byte(8'hA5);
        check("single_n0_oe", bus.data_oe_o, 1'b0);
        check("single_n0_wr", bus.wr_o, 1'b1);
        step();
        check("single_n1_oe", bus.data_oe_o, 1'b1);
        check("single_n1_wr", bus.wr_o, 1'b1);
        check("single_n1_data", bus.data_o, 8'hA5);
        step();
        check("single_n2_wr", bus.wr_o, 1'b0);
        check("single_n2_data", bus.data_o, 8'hA5);
        step();
        check("single_n3_wr", bus.wr_o, 1'b1);
        check("single_n3_oe", bus.data_oe_o, 1'b1);
        step();
        check("single_n4_oe", bus.data_oe_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_no_repeat", bus.wr_o, 1'b1);
        end

        // Fill to full with TXE# high; 17th push is dropped.
        bus.txe_i = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("full_wready", bus.wready_o, 1'b0);
        push_byte(8'hEE);
        check("full_drop_wready", bus.wready_o, 1'b0);
        bus.txe_i = 1'b0;
        wait_wr_low(8);
        for (int i = 0; i < 16; i++) begin
            check("full_stream_wr", bus.wr_o, 1'b0);
            check("full_stream_data", bus.data_o, 32'(i));
            step();
        end
        check("full_stream_end", bus.wr_o, 1'b1);

        // Burst paused by TXE# after 5 accepts; resumes at 0x05.
        bus.txe_i = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        rx0 = rx_cnt;
        bus.txe_i = 1'b0;
        wait_wr_low(8);
        for (int k = 0; k < 5; k++) begin
            check("pause_pre_data", bus.data_o, 32'(k));
            step();
        end
        check("pause_head_wr", bus.wr_o, 1'b0);
        check("pause_head_data", bus.data_o, 8'h05);
        bus.txe_i = 1'b1;
        step();
        check("pause_drive_wr", bus.wr_o, 1'b1);
        check("pause_drive_oe", bus.data_oe_o, 1'b1);
        check("pause_drive_data", bus.data_o, 8'h05);
        step();
        check("pause_idle_oe", bus.data_oe_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("pause_hold_wr", bus.wr_o, 1'b1);
            check("pause_hold_data", bus.data_o, 8'h05);
        end
        bus.txe_i = 1'b0;
        wait_wr_low(8);
        for (int k = 5; k < 16; k++) begin
            check("resume_data", bus.data_o, 32'(k));
            step();
        end
        check("resume_end", bus.wr_o, 1'b1);
        check("pause_rx_count", 32'(rx_cnt - rx0), 32'd16);

        // Reset mid-burst discards the FIFO; 0x3C is the next byte sent.
        bus.txe_i = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
        bus.txe_i = 1'b0;
        wait_wr_low(8);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_wr", bus.wr_o, 1'b1);
        check("midrst_oe", bus.data_oe_o, 1'b0);
        check("midrst_wready", bus.wready_o, 1'b1);
        rst = 1'b0;
        push_byte(8'h3C);
        wait_wr_low(8);
        check("after_rst_first", bus.data_o, 8'h3C);
        for (int i = 0; i < 4; i++) step();
        check("after_rst_idle_oe", bus.data_oe_o, 1'b0);

        // Three bytes then a long idle: SI/WU# pulses once (feature builds only).
        for (int i = 0; i < 3; i++) begin
            bus.wdata_i  = 8'($urandom_range(0, 255));
            bus.wvalid_i = 1'b1;
            step();
        end
        bus.wvalid_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        siwu_pulse = 0;
        for (int i = 0; i < 80; i++) step();
        check("siwu_pulse_count", 32'(siwu_pulse), 32'(EXP_PULSES));

        // Randomized producer and TXE# activity.
        for (int i = 0; i < 300; i++) begin
            bus.wvalid_i = ($urandom_range(0, 3) != 0);
            bus.wdata_i  = 8'($urandom_range(0, 255));
            bus.txe_i    = ($urandom_range(0, 3) == 0);
            step();
        end
        bus.wvalid_i = 1'b0;
        bus.txe_i    = 1'b0;
        for (int i = 0; i < 60; i++) step();
        check("drain_all_sent", 32'(exp_q.size()), 32'd0);
        check("drain_wready", bus.wready_o, 1'b1);
        check("drain_wr", bus.wr_o, 1'b1);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
